// File: rtl/ccu_pkg.sv
// Shared types and helpers for the CCU slave-port arbitration path.
package ccu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ccu_arb_state_e;

    function automatic int ccu_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccu_txn_counter.sv
// Saturating up/down count of in-flight master-side transactions plus full flag.
module ccu_txn_counter #(
    parameter int unsigned MaxMstTrans = 8,
    parameter int unsigned CntWidth    = $clog2(MaxMstTrans + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                full_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxMstTrans);

    logic [CntWidth-1:0] cnt_d, cnt_q;

    // A simultaneous increment and decrement cancel; both ends clamp.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == MaxCnt);

    a_no_cpl_at_zero: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(dec_i && (cnt_q == '0)));

    a_never_over_max: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (cnt_q <= MaxCnt));

endmodule

// File: rtl/ccu_slv_arbiter.sv
// Round-robin arbiter onto the shared CCU request path with an outstanding-transaction cap.
// Optional burst locking to one requester is enabled with `define CCU_SLV_ARB_LOCK_EN.
module ccu_slv_arbiter
    import ccu_pkg::*;
#(
    parameter int unsigned NoSlvPorts  = 4,
    parameter int unsigned MaxMstTrans = 8,
    parameter int unsigned IdxWidth    = ccu_idx_width(int'(NoSlvPorts)),
    parameter int unsigned CntWidth    = $clog2(MaxMstTrans + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NoSlvPorts-1:0] req_valid_i,
    input  logic [NoSlvPorts-1:0] req_last_i,
    output logic [NoSlvPorts-1:0] req_ready_o,
    output logic                  mst_valid_o,
    input  logic                  mst_ready_i,
    output logic [IdxWidth-1:0]   mst_sel_o,
    input  logic                  cpl_i,
    output logic [CntWidth-1:0]   outstanding_o,
    output logic                  full_o
);

    localparam logic [IdxWidth-1:0]   LastIdx = IdxWidth'(NoSlvPorts - 1);
    localparam logic [NoSlvPorts-1:0] OneHot0 = NoSlvPorts'(1);

    ccu_arb_state_e      state_d, state_q;
    logic [IdxWidth-1:0] rr_d, rr_q;
    logic [IdxWidth-1:0] sel_d, sel_q;
    logic [IdxWidth-1:0] cand, scan_idx, sel;
    logic                cand_vld, valid, hs, full;

`ifdef CCU_SLV_ARB_LOCK_EN
    logic lock_d, lock_q;
`else
    logic unused_last;
    assign unused_last = ^req_last_i;
`endif

    // Scan from the pointer upwards, wrapping, for the first active requester.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        scan_idx = rr_q;
        for (int i = 0; i < int'(NoSlvPorts); i++) begin
            if (!cand_vld && req_valid_i[scan_idx]) begin
                cand_vld = 1'b1;
                cand     = scan_idx;
            end
            scan_idx = (scan_idx == LastIdx) ? '0 : scan_idx + IdxWidth'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        sel     = sel_q;
        valid   = 1'b0;
`ifdef CCU_SLV_ARB_LOCK_EN
        lock_d  = lock_q;
`endif

        if (state_q == HOLD) begin
            valid = 1'b1;
        end else begin
`ifdef CCU_SLV_ARB_LOCK_EN
            if (lock_q) begin
                valid = req_valid_i[sel_q] & ~full;
            end else begin
                sel   = cand;
                valid = cand_vld & ~full;
            end
`else
            sel   = cand;
            valid = cand_vld & ~full;
`endif
        end

        // Outputs are forced quiet while reset is held, even with requests pending.
        valid = valid & rst_ni;
        hs    = valid & mst_ready_i;

        if (valid) begin
            sel_d = sel;
        end
        if ((state_q == IDLE) && valid && !mst_ready_i) begin
            state_d = HOLD;
        end

        if (hs) begin
            state_d = IDLE;
`ifdef CCU_SLV_ARB_LOCK_EN
            lock_d = ~req_last_i[sel];
            if (req_last_i[sel]) begin
                rr_d = (sel == LastIdx) ? '0 : sel + IdxWidth'(1);
            end
`else
            rr_d = (sel == LastIdx) ? '0 : sel + IdxWidth'(1);
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
`ifdef CCU_SLV_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
`ifdef CCU_SLV_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    ccu_txn_counter #(
        .MaxMstTrans (MaxMstTrans),
        .CntWidth    (CntWidth)
    ) i_txn_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (hs),
        .dec_i  (cpl_i),
        .cnt_o  (outstanding_o),
        .full_o (full)
    );

    assign full_o      = full;
    assign mst_valid_o = valid;
    assign mst_sel_o   = rst_ni ? sel : '0;
    assign req_ready_o = hs ? (OneHot0 << sel) : '0;

    // A requester waiting in HOLD must keep its request up until accepted.
    a_hold_req_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (state_q == HOLD) |-> req_valid_i[sel_q]);

    a_hold_not_full: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (state_q == HOLD) |-> !full);

endmodule

// File: tb/tb_ccu_slv_arbiter.sv
// Bench for ccu_slv_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_ccu_slv_arbiter;

    localparam int N   = 4;
    localparam int MAX = 2;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] req_valid_i, req_last_i, req_ready_o;
    logic       mst_valid_o, mst_ready_i, cpl_i, full_o;
    logic [1:0] mst_sel_o, outstanding_o;

    logic [9:0] obs, exp;
    assign obs = {mst_valid_o, mst_sel_o, req_ready_o, outstanding_o, full_o};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_rr, m_cnt, m_hold_idx, m_lock_idx;
    bit m_hold, m_locked;

    ccu_slv_arbiter #(
        .NoSlvPorts  (N),
        .MaxMstTrans (MAX)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_last_i    (req_last_i),
        .req_ready_o   (req_ready_o),
        .mst_valid_o   (mst_valid_o),
        .mst_ready_i   (mst_ready_i),
        .mst_sel_o     (mst_sel_o),
        .cpl_i         (cpl_i),
        .outstanding_o (outstanding_o),
        .full_o        (full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_last_i  = '1;
        mst_ready_i = 1'b0;
        cpl_i       = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        m_rr       = 0;
        m_cnt      = 0;
        m_hold     = 0;
        m_hold_idx = 0;
        m_locked   = 0;
        m_lock_idx = 0;
    endtask

    // Expected outputs for the current cycle from the arbitration rules.
    task automatic model_eval(input logic [3:0] v, input logic rdy,
                              output logic ev, output int es, output logic [3:0] er);
        bit any;
        int j;
        any = 0;
        es  = 0;
        ev  = 1'b0;
        if (m_hold) begin
            es = m_hold_idx;
            ev = 1'b1;
        end else if (m_locked) begin
            es = m_lock_idx;
            ev = v[es[1:0]] && (m_cnt < MAX);
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (!any && v[j[1:0]]) begin
                    any = 1;
                    es  = j;
                end
            end
            ev = any && (m_cnt < MAX);
        end
        er = (ev && rdy) ? (4'b0001 << es) : 4'b0000;
    endtask

    task automatic model_clock(input logic [3:0] l, input logic rdy, input logic c,
                               input logic ev, input int es);
        if (ev && rdy) begin
            m_cnt++;
            m_hold = 0;
`ifdef CCU_SLV_ARB_LOCK_EN
            if (!l[es[1:0]]) begin
                m_locked   = 1;
                m_lock_idx = es;
            end else begin
                m_locked = 0;
                m_rr     = (es + 1) % N;
            end
`else
            if (l === 4'bxxxx) m_rr = m_rr;
            m_rr = (es + 1) % N;
`endif
        end else if (ev) begin
            m_hold     = 1;
            m_hold_idx = es;
        end
        if (c) m_cnt--;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        req_valid_i = 4'b1111;
        mst_ready_i = 1'b1;
        req_last_i  = '1;
        cpl_i       = 1'b0;
        @(negedge clk_i);
        exp = '0;
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_held: got %b want %b", obs, exp); end
        do_reset();
        @(negedge clk_i);
        exp = '0;
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_released_idle: got %b want %b", obs, exp); end
    endtask

    task automatic test_fill_and_wrap();
        do_reset();
        mst_ready_i = 1'b1;
        req_valid_i = 4'b1011;
        @(negedge clk_i);
        exp = {1'b1, 2'd0, 4'b0001, 2'd0, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL fill_grant0: got %b want %b", obs, exp); end
        next_cycle();
        req_valid_i = 4'b1010;
        @(negedge clk_i);
        exp = {1'b1, 2'd1, 4'b0010, 2'd1, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL fill_grant1: got %b want %b", obs, exp); end
        next_cycle();
        req_valid_i = 4'b1000;
        cpl_i       = 1'b1;
        @(negedge clk_i);
        exp = {1'b0, 2'd3, 4'b0000, 2'd2, 1'b1};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL full_blocks_3: got %b want %b", obs, exp); end
        next_cycle();
        cpl_i = 1'b0;
        @(negedge clk_i);
        exp = {1'b1, 2'd3, 4'b1000, 2'd1, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL resume_grant3: got %b want %b", obs, exp); end
        next_cycle();
        req_valid_i = 4'b0000;
        cpl_i       = 1'b1;
        @(negedge clk_i);
        exp = {1'b0, 2'd0, 4'b0000, 2'd2, 1'b1};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL full_again: got %b want %b", obs, exp); end
        next_cycle();
        @(negedge clk_i);
        exp = {1'b0, 2'd0, 4'b0000, 2'd1, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL drain_one: got %b want %b", obs, exp); end
        next_cycle();
        cpl_i       = 1'b0;
        req_valid_i = 4'b1111;
        @(negedge clk_i);
        exp = {1'b1, 2'd0, 4'b0001, 2'd0, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL ptr_wrapped_to_0: got %b want %b", obs, exp); end
        next_cycle();
        req_valid_i = 4'b0000;
        @(negedge clk_i);
        exp = {1'b0, 2'd0, 4'b0000, 2'd1, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL after_wrap_count: got %b want %b", obs, exp); end
    endtask

    task automatic test_hold();
        do_reset();
        mst_ready_i = 1'b0;
        req_valid_i = 4'b0100;
        @(negedge clk_i);
        exp = {1'b1, 2'd2, 4'b0000, 2'd0, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL hold_c1: got %b want %b", obs, exp); end
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            req_valid_i = 4'b0110;
            @(negedge clk_i);
            exp = {1'b1, 2'd2, 4'b0000, 2'd0, 1'b0};
            n_tests++;
            if (obs !== exp) begin n_fail++; $display("FAIL hold_c%0d: got %b want %b", c, obs, exp); end
        end
        next_cycle();
        mst_ready_i = 1'b1;
        @(negedge clk_i);
        exp = {1'b1, 2'd2, 4'b0100, 2'd0, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL hold_handshake2: got %b want %b", obs, exp); end
        next_cycle();
        req_valid_i = 4'b0010;
        @(negedge clk_i);
        exp = {1'b1, 2'd1, 4'b0010, 2'd1, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL hold_then_grant1: got %b want %b", obs, exp); end
        next_cycle();
        req_valid_i = 4'b0000;
        mst_ready_i = 1'b0;
        @(negedge clk_i);
        exp = {1'b0, 2'd0, 4'b0000, 2'd2, 1'b1};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL hold_end_full: got %b want %b", obs, exp); end
    endtask

    task automatic test_hs_and_cpl();
        do_reset();
        mst_ready_i = 1'b1;
        req_valid_i = 4'b0001;
        @(negedge clk_i);
        exp = {1'b1, 2'd0, 4'b0001, 2'd0, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL hscpl_first: got %b want %b", obs, exp); end
        next_cycle();
        cpl_i = 1'b1;
        @(negedge clk_i);
        exp = {1'b1, 2'd0, 4'b0001, 2'd1, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL hscpl_same_cycle: got %b want %b", obs, exp); end
        next_cycle();
        cpl_i       = 1'b0;
        req_valid_i = 4'b0000;
        @(negedge clk_i);
        exp = {1'b0, 2'd0, 4'b0000, 2'd1, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL hscpl_count_kept: got %b want %b", obs, exp); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        mst_ready_i = 1'b0;
        req_valid_i = 4'b0100;
        @(negedge clk_i);
        exp = {1'b1, 2'd2, 4'b0000, 2'd0, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL rsthold_pre: got %b want %b", obs, exp); end
        next_cycle();
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        exp = '0;
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL rsthold_async_clear: got %b want %b", obs, exp); end
        next_cycle();
        rst_ni      = 1'b1;
        req_valid_i = 4'b0110;
        mst_ready_i = 1'b1;
        @(negedge clk_i);
        exp = {1'b1, 2'd1, 4'b0010, 2'd0, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL rsthold_first_grant: got %b want %b", obs, exp); end
        next_cycle();
        req_valid_i = 4'b0000;
        mst_ready_i = 1'b0;
        @(negedge clk_i);
        exp = {1'b0, 2'd0, 4'b0000, 2'd1, 1'b0};
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL rsthold_after: got %b want %b", obs, exp); end
    endtask

`ifdef CCU_SLV_ARB_LOCK_EN
    task automatic test_lock();
        logic [9:0] lexp [7];
        logic [3:0] lv   [7];
        logic [3:0] ll   [7];
        logic       lc   [7];
        lv = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0000};
        ll = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0001};
        lc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        lexp = '{{1'b1, 2'd0, 4'b0001, 2'd0, 1'b0},
                 {1'b1, 2'd1, 4'b0010, 2'd1, 1'b0},
                 {1'b0, 2'd1, 4'b0000, 2'd2, 1'b1},
                 {1'b1, 2'd1, 4'b0010, 2'd1, 1'b0},
                 {1'b1, 2'd1, 4'b0010, 2'd1, 1'b0},
                 {1'b1, 2'd0, 4'b0001, 2'd1, 1'b0},
                 {1'b0, 2'd0, 4'b0000, 2'd2, 1'b1}};
        do_reset();
        mst_ready_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_valid_i = lv[c];
            req_last_i  = ll[c];
            cpl_i       = lc[c];
            @(negedge clk_i);
            n_tests++;
            if (obs !== lexp[c]) begin
                n_fail++;
                $display("FAIL lock_step%0d: got %b want %b", c, obs, lexp[c]);
            end
            next_cycle();
        end
        cpl_i       = 1'b0;
        req_valid_i = '0;
    endtask
`endif

    task automatic test_random();
        logic [3:0] v, l, er;
        logic       rdy, c, ev;
        int         es;
        do_reset();
        v   = '0;
        l   = '1;
        rdy = 1'b0;
        c   = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid_i = v;
            req_last_i  = l;
            mst_ready_i = rdy;
            cpl_i       = c;
            @(negedge clk_i);
            model_eval(v, rdy, ev, es, er);
            exp = {ev, 2'(es), er, 2'(m_cnt), (m_cnt == MAX)};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %b want %b", cyc, obs, exp);
            end
            @(posedge clk_i);
            model_clock(l, rdy, c, ev, es);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && !(ev && rdy && (es == i)))) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                end
            end
            l   = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            c   = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_fill_and_wrap();
        test_hold();
        test_hs_and_cpl();
        test_reset_in_hold();
`ifdef CCU_SLV_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
